// File: rtl/riscv_pkg.sv
// riscv_pkg: shared divider opcode/state types and constants
package riscv_pkg;
  localparam int XLEN = 32;
  localparam logic [31:0] DIV_INT_MIN = 32'h8000_0000;
  typedef enum logic [1:0] {DIV = 2'b00, DIVU = 2'b01, REM = 2'b10, REMU = 2'b11} div_op_t;
  typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} div_state_t;
endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration
module div_step #(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] rem,
  input  logic            msb,
  input  logic [XLEN-1:0] divisor,
  output logic [XLEN-1:0] rem_nxt,
  output logic            q_bit
);
  logic [XLEN:0] diff;
  assign diff    = {rem, msb} - {1'b0, divisor};
  assign q_bit   = ~diff[XLEN];
  assign rem_nxt = q_bit ? diff[XLEN-1:0] : {rem[XLEN-2:0], msb};
endmodule

// File: rtl/div_unit.sv
// div_unit: iterative RV32M DIV/DIVU/REM/REMU with stall and single-cycle register-file write
module div_unit #(
  parameter int XLEN  = 32,
  parameter int CNT_W = 5
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            start,
  input  logic [1:0]      op,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  input  logic [4:0]      rd_addr,
  output logic            busy,
  output logic            wr_rd_en,
  output logic [4:0]      addr_wr,
  output logic [XLEN-1:0] write_port
);
  import riscv_pkg::*;
  div_state_t      state;
  logic [1:0]      op_q;
  logic [4:0]      rd_q;
  logic            neg_q, neg_r;
  logic [XLEN-1:0] rem, dvd, dsr, rem_nxt, abs1, abs2, spec_res, q_fix, r_fix;
  logic            q_bit, sgn_in, sgn_q, div0, ovf;
  logic [CNT_W-1:0] cnt;
  div_step #(.XLEN(XLEN)) u_step (
    .rem(rem), .msb(dvd[XLEN-1]), .divisor(dsr), .rem_nxt(rem_nxt), .q_bit(q_bit)
  );
  assign busy     = state != IDLE;
  assign sgn_in   = ~op[0];
  assign abs1     = (sgn_in && rs1_val[XLEN-1]) ? -rs1_val : rs1_val;
  assign abs2     = (sgn_in && rs2_val[XLEN-1]) ? -rs2_val : rs2_val;
  assign div0     = rs2_val == '0;
  assign ovf      = sgn_in && rs1_val == DIV_INT_MIN && rs2_val == '1;
  assign spec_res = div0 ? (op[1] ? rs1_val : '1) : (op[1] ? '0 : DIV_INT_MIN);
  assign sgn_q    = ~op_q[0];
  assign q_fix    = (sgn_q && neg_q) ? -dvd : dvd;
  assign r_fix    = (sgn_q && neg_r) ? -rem : rem;
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      op_q       <= '0;
      rd_q       <= '0;
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
      rem        <= '0;
      dvd        <= '0;
      dsr        <= '0;
      cnt        <= '0;
      wr_rd_en   <= 1'b0;
      addr_wr    <= '0;
      write_port <= '0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q  <= op;
          rd_q  <= rd_addr;
          neg_q <= rs1_val[XLEN-1] ^ rs2_val[XLEN-1];
          neg_r <= rs1_val[XLEN-1];
          dvd   <= abs1;
          dsr   <= abs2;
          rem   <= '0;
          cnt   <= '0;
          if (div0 || ovf) begin
            state      <= DONE;
            write_port <= spec_res;
            wr_rd_en   <= rd_addr != '0;
            addr_wr    <= rd_addr;
          end else begin
            state <= CALC;
          end
        end
        CALC: begin
          rem <= rem_nxt;
          dvd <= {dvd[XLEN-2:0], q_bit};
          cnt <= cnt + 1'b1;
          if (cnt == '1) state <= FIX;
        end
        FIX: begin
          write_port <= op_q[1] ? r_fix : q_fix;
          wr_rd_en   <= rd_q != '0;
          addr_wr    <= rd_q;
          state      <= DONE;
        end
        default: begin
          wr_rd_en <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: randomized and directed checks of div_unit against an arithmetic reference
module tb_div_unit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  op = '0;
  logic [31:0] rs1_val = '0, rs2_val = '0;
  logic [4:0]  rd_addr = '0;
  logic        busy, wr_rd_en;
  logic [4:0]  addr_wr;
  logic [31:0] write_port;
  int vectors = 0, miscompares = 0;
  int m_cyc = -1, m_lat = 1, n_wr = 0, wr_cyc = 0;
  logic [31:0] m_res = '0, m_wp = '0;
  logic [4:0]  m_rd = '0, m_addr = '0;
  div_unit dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .rs1_val(rs1_val), .rs2_val(rs2_val),
    .rd_addr(rd_addr), .busy(busy), .wr_rd_en(wr_rd_en), .addr_wr(addr_wr), .write_port(write_port)
  );
  always #5 clk = ~clk;
  function automatic logic [31:0] ref_res(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic [31:0] q, r;
    if (b == 0) begin
      q = '1;
      r = a;
    end else if (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
      q = a;
      r = 0;
    end else if (!o[0]) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
    end else begin
      q = a / b;
      r = a % b;
    end
    return o[1] ? r : q;
  endfunction
  function automatic int ref_lat(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    return (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF)) ? 1 : 34;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h (model cycle %0d)", name, act, exp, m_cyc);
    end
  endtask
  always @(posedge clk) begin
    if (rst) begin
      m_cyc  = -1;
      m_wp   = '0;
      m_addr = '0;
    end else if (m_cyc < 0) begin
      if (start) begin
        m_res = ref_res(op, rs1_val, rs2_val);
        m_lat = ref_lat(op, rs1_val, rs2_val);
        m_rd  = rd_addr;
        m_cyc = 1;
      end
    end else if (m_cyc == m_lat) begin
      m_cyc = -1;
    end else begin
      m_cyc++;
    end
    if (m_cyc == m_lat) begin
      m_wp   = m_res;
      m_addr = m_rd;
    end
  end
  always @(negedge clk) begin
    chk("busy", {31'b0, busy}, {31'b0, m_cyc >= 1});
    chk("wr_rd_en", {31'b0, wr_rd_en}, {31'b0, m_cyc == m_lat && m_rd != 0});
    chk("addr_wr", {27'b0, addr_wr}, {27'b0, m_addr});
    chk("write_port", write_port, m_wp);
    if (wr_rd_en === 1'b1) begin
      n_wr++;
      wr_cyc = m_cyc;
    end
  end
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
    @(negedge clk);
    op = o;
    rs1_val = a;
    rs2_val = b;
    rd_addr = rd;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask
  task automatic wait_idle(input string name);
    for (int i = 0; i < 60 && busy !== 1'b0; i++) @(negedge clk);
    chk({name, "_idle"}, {31'b0, busy}, 32'd0);
  endtask
  task automatic wait_cyc(input int c);
    for (int i = 0; i < 60 && m_cyc != c; i++) @(negedge clk);
  endtask
  task automatic run_lit(input string name, input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input logic [31:0] lit, input int lat);
    int w0;
    w0 = n_wr;
    issue(o, a, b, rd);
    wait_idle(name);
    chk({name, "_result"}, write_port, lit);
    chk({name, "_writes"}, n_wr - w0, (rd != 0) ? 32'd1 : 32'd0);
    if (rd != 0) chk({name, "_cycle"}, wr_cyc, lat);
  endtask
  initial begin
    int w0;
    logic [31:0] a, b;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    run_lit("divu_100_7", 2'b01, 32'd100, 32'd7, 5'd5, 32'd14, 34);
    chk("divu_addr", {27'b0, addr_wr}, 32'd5);
    run_lit("remu_100_7", 2'b11, 32'd100, 32'd7, 5'd6, 32'd2, 34);
    run_lit("div_m7_2", 2'b00, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD, 34);
    run_lit("rem_m7_2", 2'b10, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF, 34);
    run_lit("rem_7_m2", 2'b10, 32'd7, 32'hFFFF_FFFE, 5'd3, 32'd1, 34);
    run_lit("div_by0", 2'b00, 32'h1234, 32'd0, 5'd4, 32'hFFFF_FFFF, 1);
    run_lit("remu_by0", 2'b11, 32'h1234, 32'd0, 5'd8, 32'h1234, 1);
    run_lit("div_ovf", 2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9, 32'h8000_0000, 1);
    run_lit("rem_ovf", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd10, 32'd0, 1);
    run_lit("divu_ovf", 2'b01, 32'h8000_0000, 32'hFFFF_FFFF, 5'd11, 32'd0, 34);
    run_lit("rd_zero", 2'b01, 32'd100, 32'd7, 5'd0, 32'd14, 34);
    w0 = n_wr;
    issue(2'b01, 32'd1000, 32'd3, 5'd7);
    wait_cyc(10);
    op = 2'b11;
    rs1_val = 32'd5;
    rs2_val = 32'd2;
    rd_addr = 5'd12;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_cyc(34);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    chk("busy_start_writes", n_wr - w0, 32'd1);
    chk("busy_start_result", write_port, 32'd333);
    chk("busy_start_addr", {27'b0, addr_wr}, 32'd7);
    w0 = n_wr;
    issue(2'b01, 32'hDEAD_BEEF, 32'd17, 5'd13);
    wait_cyc(15);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {31'b0, busy}, 32'd0);
    chk("rst_data", write_port, 32'd0);
    chk("rst_addr", {27'b0, addr_wr}, 32'd0);
    repeat (40) @(negedge clk);
    chk("rst_writes", n_wr - w0, 32'd0);
    run_lit("after_rst", 2'b01, 32'hDEAD_BEEF, 32'd17, 5'd13, 32'hDEAD_BEEF / 32'd17, 34);
    for (int i = 0; i < 40; i++) begin
      a = $urandom;
      case ($urandom_range(0, 4))
        0: b = $urandom_range(1, 20);
        1: b = 32'd0;
        2: begin
          b = 32'hFFFF_FFFF;
          if ($urandom_range(0, 1) == 1) a = 32'h8000_0000;
        end
        3: b = -$urandom_range(1, 20);
        default: b = $urandom;
      endcase
      w0 = n_wr;
      rd_addr = 5'($urandom_range(0, 31));
      issue(2'($urandom_range(0, 3)), a, b, rd_addr);
      wait_idle("rand");
      chk("rand_writes", n_wr - w0, (m_rd != 0) ? 32'd1 : 32'd0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Iterative 32-bit RV32M divider implementing DIV, DIVU, REM and REMU.
- Sits in the execute stage, directly upstream of the register file write port.
- Accepts rs1/rs2 operands and the destination index, and raises a pipeline stall while it computes.
- Drives a single-cycle register-file write request when the result is ready.

Parameters:
- XLEN, 32, operand and result width.
- CNT_W, 5, width of the iteration counter (log2 XLEN).

Ports:
- clk  input  1  system clock; all state updates on posedge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a divide; honoured only in IDLE.
- op  input  2  divide opcode, equal to funct3[1:0]: 00 DIV, 01 DIVU, 10 REM, 11 REMU.
- rs1_val  input  XLEN  dividend.
- rs2_val  input  XLEN  divisor.
- rd_addr  input  5  destination register index.
- busy  output  1  high in every state except IDLE; the core uses it as a stall.
- wr_rd_en  output  1  register-file write enable, pulsed for exactly one cycle.
- addr_wr  output  5  destination index, valid when wr_rd_en=1.
- write_port  output  XLEN  result, valid when wr_rd_en=1.

Behaviour:
- Reset: state=IDLE, busy=0, wr_rd_en=0, addr_wr=0, write_port=0, all internal registers 0.
- rst has priority over everything, including mid-operation: the unit returns to IDLE and no write is issued.
- States: IDLE, CALC, FIX, DONE. busy = (state != IDLE).
- IDLE, start=0: stay in IDLE.
- IDLE, start=1: latch op, rd_addr and both operands.
  - Signed ops (op[0]=0) take the absolute values of the operands.
  - Record neg_q = sign(rs1) XOR sign(rs2) and neg_r = sign(rs1).
  - Special case, divisor==0: quotient=all ones, remainder=rs1. Go directly to DONE.
  - Special case, signed op with rs1=0x80000000 and rs2=0xFFFFFFFF: quotient=0x80000000, remainder=0. Go directly to DONE.
  - Otherwise: clear the remainder, set count=0, go to CALC.
- CALC: one restoring step per cycle, MSB first.
  - Shift {rem, dividend} left by 1 and trial-subtract the divisor from the upper bits.
  - If the result is non-negative, keep it and set the quotient bit to 1; otherwise restore and set the bit to 0.
  - After the step with count=31, go to FIX; otherwise increment count.
- FIX:
  - Negate the quotient if the op is signed and neg_q=1.
  - Negate the remainder if the op is signed and neg_r=1.
  - Select the quotient when op[1]=0, the remainder when op[1]=1, and register it into write_port. Go to DONE.
- DONE:
  - wr_rd_en=1 for this cycle only, addr_wr = latched rd_addr.
  - wr_rd_en stays 0 when rd_addr=0; the write is suppressed but timing is unchanged.
  - Next state is IDLE.
- Outputs are registered. write_port and addr_wr hold their last value after DONE; only wr_rd_en returns to 0.
- Latency, counted from the posedge that samples start (edge 0):
  - Normal ops: 32 CALC cycles and 1 FIX cycle; wr_rd_en is high in cycle 34. The unit accepts the next start on the edge ending DONE plus one, i.e. when busy is low.
  - Special cases: wr_rd_en is high in cycle 1.
- start while busy=1, including the DONE cycle: ignored, with no queueing.
- The register file samples the write on its own clock edge within the DONE cycle. This block requires no extra hold time.
- Remainder arithmetic uses an XLEN+1-bit subtractor. No other widening.

Decomposition:
- Shared package (riscv_pkg):
  - enum div_op_t {DIV=2'b00, DIVU=2'b01, REM=2'b10, REMU=2'b11}.
  - enum div_state_t {IDLE, CALC, FIX, DONE}.
  - Constants XLEN=32, DIV_INT_MIN=32'h8000_0000.
- One natural sub-module: div_step, a combinational single restoring iteration.
  - Inputs: rem, dividend MSB, divisor.
  - Outputs: next rem, quotient bit.
  - Instantiated once in div_unit.

Test Plan:
- DIVU 100/7, rd=5 -> busy high for cycles 1-34; wr_rd_en=1 only in cycle 34 with addr_wr=5, write_port=14. REMU with the same operands -> 2.
- DIV -7/2 -> 0xFFFFFFFD (-3). REM -7/2 -> 0xFFFFFFFF (-1). REM 7/-2 -> 1.
- DIV x/0 with x=0x1234 -> 0xFFFFFFFF in cycle 1. REMU 0x1234/0 -> 0x1234 in cycle 1.
- DIV 0x80000000/0xFFFFFFFF -> 0x80000000 in cycle 1. REM with the same operands -> 0. DIVU with the same operands -> 0 after 34 cycles.
- Protocol cases:
  - rd_addr=0 -> full latency, busy toggles, wr_rd_en never asserted.
  - Second start pulsed in cycle 10 and again in DONE -> ignored; exactly one write.
- rst asserted in cycle 15 of a DIVU -> next cycle busy=0, all outputs 0, no write. A start issued afterwards completes normally with the correct result.
